spi_master_engine: RTL and testbench
====================================

// Module: spi_master_engine
// PURPOSE
//  Parameterised SPI master. Turns one parallel word into one full-duplex, MSB-first SPI frame
//  in any of the four CPOL/CPHA modes. Drives serial_clock, chip_select and serial_out, and
//  captures serial_in. Sits between the register/command layer and the external SPI slave pins.
//  Uses a valid/ready request handshake and returns a one-cycle response pulse.
// PARAMETERS
//  DATA_WIDTH     32   bits per frame; one frame per request
//  DIVIDER_WIDTH  16   width of clock_divider; SPI half-period = clock_divider+1 clock cycles
// PORTS
//  clock           in   1    system clock
//  reset_n         in   1    asynchronous, active-low reset
//  request_valid   in   1    request present
//  request_ready   out  1    engine idle and able to accept a request
//  request_data    in   DW   word to shift out
//  clock_divider   in   DIVW half-period select, latched at accept
//  clock_polarity  in   1    CPOL, latched at accept
//  clock_phase     in   1    CPHA, latched at accept
//  response_valid  out  1    one-cycle pulse: response_data is valid
//  response_data   out  DW   word shifted in from serial_in
//  busy            out  1    high from accept until request_ready returns
//  serial_clock    out  1    SPI clock
//  chip_select     out  1    active-low slave select
//  serial_out      out  1    MOSI
//  serial_in       in   1    MISO
// BEHAVIOUR
//  Reset (async): state=IDLE, chip_select=1, serial_clock=0, serial_out=0, response_valid=0,
//   response_data=0, busy=0. request_ready=1 in IDLE only. All pin outputs are registered.
//  Divider: a half-period tick fires every d+1 cycles, where d is the latched clock_divider.
//   The counter restarts on every state change.
//  FSM: IDLE -> SETUP -> SHIFT -> HOLD -> GAP -> IDLE.
//  IDLE: serial_clock follows clock_polarity (registered), chip_select=1.
//   An accept is request_valid && request_ready. It latches data, divider and mode, then goes to SETUP.
//  SETUP (1 half-period): chip_select=0; serial_clock=CPOL.
//   For CPHA=0, serial_out = data MSB from the first SETUP cycle.
//  SHIFT: exactly 2*DATA_WIDTH half-period ticks. Each tick toggles serial_clock.
//   Leading edges are odd ticks; trailing edges are even ticks.
//   CPHA=0: sample serial_in on leading edges; shift serial_out on trailing edges, except the last.
//   CPHA=1: shift serial_out on leading edges (first one presents the MSB); sample on trailing edges.
//  HOLD (1 half-period): serial_clock=CPOL, chip_select held low.
//  End of HOLD: chip_select=1, response_valid=1 for one cycle, response_data=received word.
//  GAP (1 half-period): chip_select stays high; request_ready is low. Then go to IDLE.
//  Timing, with accept at cycle 0 and P = d+1:
//   - chip_select falls at cycle 1;
//   - tick k (1..2*DW) at cycle 1+k*P;
//   - response_valid and chip_select rise at 1+(2*DW+1)*P;
//   - request_ready returns at 1+(2*DW+2)*P.
//  Back-to-back: a request held valid is accepted in the first IDLE cycle.
//   Minimum chip_select-high time between frames is P+1 cycles.
//  Input changes during a frame (mode, divider, request_data) are ignored until the next accept.
//  request_valid while busy is not accepted; it is neither dropped nor queued by the engine.
//  Reset mid-frame: pins return to reset values immediately; no response_valid is produced.
//  Divider 0 is legal: serial_clock = clock/2.
// STRUCTURE
//  spi_pkg: typedef enum spi_state_t {IDLE,SETUP,SHIFT,HOLD,GAP}; typedef struct spi_mode_t
//   {polarity, phase}; localparam SPI_DEFAULT_DATA_WIDTH=32.
//  Sub-module spi_half_period_timer: counter, restart input, tick output.
//  Shift register and FSM live in spi_master_engine.
// TESTING
//  1 Mode 0, d=3, request 0x12345678, attached to spi_slave_sim_model (CPOL=0,CPHA=0):
//    -> response_data=0xACDC1112; slave read_data=0x12345678; response_valid at cycle 261.
//  2 Loopback (serial_in=serial_out), d=1, all four modes, 0xA5A5F00F -> response 0xA5A5F00F;
//    serial_clock idles at CPOL; exactly 32 leading edges per frame.
//  3 d=0, one frame -> chip_select low cycles 1..65; response_valid at cycle 66;
//    request_ready at cycle 67.
//  4 request_valid held high for 2 frames, d=2 -> chip_select high >= 4 cycles between frames;
//    request_ready low throughout each frame; two response pulses.
//  5 Toggle clock_polarity and request_data mid-frame -> frame unaffected;
//    the new mode applies from the next accept.
//  6 reset_n low at tick 20 -> chip_select=1, serial_clock=0, no response_valid;
//    a frame after release completes correctly.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared types and defaults for the SPI master engine.
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    GAP
  } spi_state_t;

  typedef struct packed {
    logic polarity;
    logic phase;
  } spi_mode_t;

  localparam int SPI_DEFAULT_DATA_WIDTH = 32;

endpackage

// File: rtl/spi_half_period_timer.sv
// Half-period tick generator: tick is high on the last cycle of every (divider+1)-cycle window.
module spi_half_period_timer #(
  parameter int DIVIDER_WIDTH = 16
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     restart,
  input  logic [DIVIDER_WIDTH-1:0] divider,
  output logic                     tick
);

  logic [DIVIDER_WIDTH-1:0] count;

  assign tick = (count == divider);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (restart || tick) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/spi_master_engine.sv
// SPI master: one request word becomes one full-duplex MSB-first frame in any CPOL/CPHA mode.
module spi_master_engine
  import spi_pkg::*;
#(
  parameter int DATA_WIDTH    = SPI_DEFAULT_DATA_WIDTH,
  parameter int DIVIDER_WIDTH = 16
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     request_valid,
  output logic                     request_ready,
  input  logic [DATA_WIDTH-1:0]    request_data,
  input  logic [DIVIDER_WIDTH-1:0] clock_divider,
  input  logic                     clock_polarity,
  input  logic                     clock_phase,
  output logic                     response_valid,
  output logic [DATA_WIDTH-1:0]    response_data,
  output logic                     busy,
  output logic                     serial_clock,
  output logic                     chip_select,
  output logic                     serial_out,
  input  logic                     serial_in,
  output logic [2:0]               debug_state
);

  localparam int TICK_WIDTH = $clog2(2 * DATA_WIDTH + 1);
  localparam logic [TICK_WIDTH-1:0] LAST_TICK = TICK_WIDTH'(2 * DATA_WIDTH);

  spi_state_t                state;
  spi_state_t                state_next;
  spi_mode_t                 mode_q;
  logic [DIVIDER_WIDTH-1:0]  divider_q;
  logic [DATA_WIDTH-1:0]     tx_q;
  logic [DATA_WIDTH-1:0]     rx_q;
  logic [TICK_WIDTH-1:0]     tick_count;
  logic [TICK_WIDTH-1:0]     tick_next;
  logic                      tick;
  logic                      accept;
  logic                      edge_event;
  logic                      sample_event;
  logic                      shift_event;
  logic                      frame_done;

  // Handshake: a request transfers on a clock edge where request_valid && request_ready;
  // request_ready is high only in IDLE, and a waiting request is never dropped or queued here.
  assign request_ready = (state == IDLE);
  assign busy          = (state != IDLE);
  assign debug_state   = state;
  assign tick_next     = tick_count + 1'b1;

  spi_half_period_timer #(
    .DIVIDER_WIDTH(DIVIDER_WIDTH)
  ) u_timer (
    .clock   (clock),
    .reset_n (reset_n),
    .restart (state_next != state),
    .divider (divider_q),
    .tick    (tick)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // The tick that closes SETUP is the first SPI clock edge, so SHIFT holds the remaining edges.
  always_comb begin
    state_next   = state;
    accept       = 1'b0;
    edge_event   = 1'b0;
    sample_event = 1'b0;
    shift_event  = 1'b0;
    frame_done   = 1'b0;
    case (state)
      IDLE: begin
        if (request_valid) begin
          accept     = 1'b1;
          state_next = SETUP;
        end
      end
      SETUP: begin
        if (tick) begin
          edge_event = 1'b1;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        if (tick) begin
          edge_event = 1'b1;
          if (tick_next == LAST_TICK) begin
            state_next = HOLD;
          end
        end
      end
      HOLD: begin
        if (tick) begin
          frame_done = 1'b1;
          state_next = GAP;
        end
      end
      GAP: begin
        if (tick) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    // Odd ticks are leading edges: CPHA=0 samples there, CPHA=1 samples on the even ones.
    if (edge_event) begin
      sample_event = tick_next[0] ^ mode_q.phase;
      shift_event  = !(tick_next[0] ^ mode_q.phase) && (tick_next != LAST_TICK);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mode_q         <= '0;
      divider_q      <= '0;
      tx_q           <= '0;
      rx_q           <= '0;
      tick_count     <= '0;
      chip_select    <= 1'b1;
      serial_clock   <= 1'b0;
      serial_out     <= 1'b0;
      response_valid <= 1'b0;
      response_data  <= '0;
    end else begin
      response_valid <= frame_done;
      if (accept) begin
        mode_q.polarity <= clock_polarity;
        mode_q.phase    <= clock_phase;
        divider_q       <= clock_divider;
        tick_count      <= '0;
        rx_q            <= '0;
        chip_select     <= 1'b0;
        serial_clock    <= clock_polarity;
        if (!clock_phase) begin
          serial_out <= request_data[DATA_WIDTH-1];
          tx_q       <= request_data << 1;
        end else begin
          tx_q <= request_data;
        end
      end else if (state == IDLE) begin
        serial_clock <= clock_polarity;
        chip_select  <= 1'b1;
      end
      if (edge_event) begin
        serial_clock <= ~serial_clock;
        tick_count   <= tick_next;
      end
      if (sample_event) begin
        rx_q <= {rx_q[DATA_WIDTH-2:0], serial_in};
      end
      if (shift_event) begin
        serial_out <= tx_q[DATA_WIDTH-1];
        tx_q       <= tx_q << 1;
      end
      if (frame_done) begin
        chip_select   <= 1'b1;
        serial_clock  <= mode_q.polarity;
        response_data <= rx_q;
      end
    end
  end

endmodule

// File: tb/tb_spi_master_engine.sv
// Self-checking bench for spi_master_engine: slave model, loopback, timing and reset scenarios.
`timescale 1ns/1ps
module tb_spi_master_engine;

  localparam int DW     = 32;
  localparam int DIVW   = 16;
  localparam int BUDGET = 3000;

  logic            clock = 1'b0;
  logic            reset_n;
  logic            request_valid;
  logic            request_ready;
  logic [DW-1:0]   request_data;
  logic [DIVW-1:0] clock_divider;
  logic            clock_polarity;
  logic            clock_phase;
  logic            response_valid;
  logic [DW-1:0]   response_data;
  logic            busy;
  logic            serial_clock;
  logic            chip_select;
  logic            serial_out;
  logic            serial_in;
  logic [2:0]      debug_state;

  int checks   = 0;
  int failures = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] got_q[$];
  int cyc = 0;

  // Serial-in source: loopback of serial_out, or a CPOL=0/CPHA=0 slave model.
  logic          loopback = 1'b1;
  logic          slave_miso = 1'b0;
  logic [DW-1:0] slave_word = '0;
  logic [DW-1:0] slave_tx = '0;
  logic [DW-1:0] slave_rx = '0;

  assign serial_in = loopback ? serial_out : slave_miso;

  spi_master_engine #(
    .DATA_WIDTH    (DW),
    .DIVIDER_WIDTH (DIVW)
  ) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .request_valid  (request_valid),
    .request_ready  (request_ready),
    .request_data   (request_data),
    .clock_divider  (clock_divider),
    .clock_polarity (clock_polarity),
    .clock_phase    (clock_phase),
    .response_valid (response_valid),
    .response_data  (response_data),
    .busy           (busy),
    .serial_clock   (serial_clock),
    .chip_select    (chip_select),
    .serial_out     (serial_out),
    .serial_in      (serial_in),
    .debug_state    (debug_state)
  );

  // Clock/reset block
  always #5 clock = ~clock;
  always @(posedge clock) cyc++;

  always @(negedge chip_select) begin
    slave_tx   = slave_word;
    slave_rx   = '0;
    slave_miso = slave_tx[DW-1];
  end
  always @(posedge serial_clock) if (!chip_select) slave_rx = {slave_rx[DW-2:0], serial_out};
  always @(negedge serial_clock) if (!chip_select) begin
    slave_tx   = slave_tx << 1;
    slave_miso = slave_tx[DW-1];
  end

  // Pin monitor, sampled on the falling edge; times are in cycles of the cyc counter.
  int   acc_cyc = 0, acc_count = 0, cs_fall_cyc = 0, cs_rise_cyc = 0, rv_cyc = 0, ready_cyc = 0;
  int   rsp_count = 0, lead_edges = 0, toggles = 0, ready_in_frame = 0, busy_bad = 0;
  int   cs_gap = 0, last_rise = -1;
  int   acc_hist[$];
  logic frame_cpol = 1'b0, prev_cs = 1'b1, prev_sclk = 1'b0, prev_ready = 1'b1;

  always @(negedge clock) begin
    if (request_valid && request_ready) begin
      acc_cyc = cyc;
      acc_count++;
      acc_hist.push_back(cyc);
      lead_edges = 0;
      toggles    = 0;
      frame_cpol = clock_polarity;
    end
    if (prev_cs && !chip_select) begin
      cs_fall_cyc = cyc;
      if (last_rise >= 0) cs_gap = cyc - last_rise;
    end
    if (!prev_cs && chip_select) begin
      cs_rise_cyc = cyc;
      last_rise   = cyc;
    end
    if (!chip_select && serial_clock != prev_sclk) begin
      toggles++;
      if (serial_clock != frame_cpol) lead_edges++;
    end
    if (response_valid) begin
      rv_cyc = cyc;
      rsp_count++;
      got_q.push_back(response_data);
    end
    if (!prev_ready && request_ready) ready_cyc = cyc;
    if (request_ready && !chip_select) ready_in_frame++;
    if (busy === request_ready) busy_bad++;
    prev_cs    = chip_select;
    prev_sclk  = serial_clock;
    prev_ready = request_ready;
  end

  // Driver tasks
  task automatic wait_accepts(input int target);
    int n = 0;
    while (acc_count < target && n < BUDGET) begin
      @(negedge clock); #1; n++;
    end
    if (acc_count < target) begin
      checks++; failures++;
      $display("FAIL accept_timeout: accepts=%0d required=%0d", acc_count, target);
    end
  endtask

  task automatic launch(input logic [DW-1:0] data, input int d, input logic cpol, input logic cpha);
    int start = acc_count;
    @(posedge clock); #1;
    request_data   = data;
    clock_divider  = DIVW'(d);
    clock_polarity = cpol;
    clock_phase    = cpha;
    request_valid  = 1'b1;
    wait_accepts(start + 1);
    @(posedge clock); #1;
    request_valid = 1'b0;
  endtask

  task automatic finish_frame(input int target);
    int n = 0;
    while ((rsp_count < target || !request_ready) && n < BUDGET) begin
      @(negedge clock); #1; n++;
    end
    if (n >= BUDGET) begin
      checks++; failures++;
      $display("FAIL frame_timeout: responses=%0d required=%0d", rsp_count, target);
    end
  endtask

  function automatic logic [DW-1:0] pop_got();
    return (got_q.size() != 0) ? got_q.pop_front() : 'x;
  endfunction

  // Scenario tasks
  task automatic test_reset();
    reset_n = 1'b0; request_valid = 1'b0; request_data = '0;
    clock_divider = '0; clock_polarity = 1'b0; clock_phase = 1'b0;
    repeat (3) @(negedge clock);
    checks++;
    if ({chip_select, serial_clock, serial_out, response_valid, busy, request_ready} !== 6'b100001) begin
      failures++;
      $display("FAIL reset_pins: got %b required 100001",
               {chip_select, serial_clock, serial_out, response_valid, busy, request_ready});
    end
    checks++;
    if (response_data !== '0) begin
      failures++; $display("FAIL reset_data: got %h required 0", response_data);
    end
    #1 reset_n = 1'b1;
    repeat (2) @(negedge clock);
    checks++;
    if ({chip_select, busy, request_ready} !== 3'b101) begin
      failures++; $display("FAIL idle_after_reset: got %b required 101", {chip_select, busy, request_ready});
    end
  endtask

  task automatic test_slave_mode0();
    int target = rsp_count + 1;
    logic [DW-1:0] got, exp;
    loopback = 1'b0;
    slave_word = 32'hACDC1112;
    exp_q.push_back(32'hACDC1112);
    launch(32'h12345678, 3, 1'b0, 1'b0);
    finish_frame(target);
    got = pop_got(); exp = exp_q.pop_front();
    checks++;
    if (got !== exp) begin failures++; $display("FAIL slave_response: got %h required %h", got, exp); end
    checks++;
    if (slave_rx !== 32'h12345678) begin
      failures++; $display("FAIL slave_read: got %h required 12345678", slave_rx);
    end
    checks++;
    if (rv_cyc - acc_cyc != 261) begin
      failures++; $display("FAIL slave_rv_cycle: got %0d required 261", rv_cyc - acc_cyc);
    end
    checks++;
    if (cs_fall_cyc - acc_cyc != 1) begin
      failures++; $display("FAIL slave_cs_fall: got %0d required 1", cs_fall_cyc - acc_cyc);
    end
    loopback = 1'b1;
  endtask

  task automatic test_modes();
    for (int m = 0; m < 4; m++) begin
      int target = rsp_count + 1;
      logic cpol = m[1];
      logic cpha = m[0];
      logic [DW-1:0] got, exp;
      exp_q.push_back(32'hA5A5F00F);
      launch(32'hA5A5F00F, 1, cpol, cpha);
      finish_frame(target);
      got = pop_got(); exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin failures++; $display("FAIL mode%0d_data: got %h required %h", m, got, exp); end
      checks++;
      if (lead_edges != DW) begin
        failures++; $display("FAIL mode%0d_leading_edges: got %0d required %0d", m, lead_edges, DW);
      end
      checks++;
      if (serial_clock !== cpol) begin
        failures++; $display("FAIL mode%0d_idle_sclk: got %b required %b", m, serial_clock, cpol);
      end
      checks++;
      if (rv_cyc - acc_cyc != 131 || ready_cyc - acc_cyc != 133) begin
        failures++;
        $display("FAIL mode%0d_timing: rv %0d ready %0d required 131 133", m, rv_cyc - acc_cyc, ready_cyc - acc_cyc);
      end
    end
  endtask

  task automatic test_divider_zero();
    int target = rsp_count + 1;
    logic [DW-1:0] word = $urandom;
    logic [DW-1:0] got, exp;
    exp_q.push_back(word);
    launch(word, 0, 1'b0, 1'b0);
    finish_frame(target);
    got = pop_got(); exp = exp_q.pop_front();
    checks++;
    if (got !== exp) begin failures++; $display("FAIL div0_data: got %h required %h", got, exp); end
    checks++;
    if (cs_fall_cyc - acc_cyc != 1 || cs_rise_cyc - acc_cyc != 66) begin
      failures++;
      $display("FAIL div0_cs_window: fall %0d rise %0d required 1 66", cs_fall_cyc - acc_cyc, cs_rise_cyc - acc_cyc);
    end
    checks++;
    if (rv_cyc - acc_cyc != 66) begin
      failures++; $display("FAIL div0_rv_cycle: got %0d required 66", rv_cyc - acc_cyc);
    end
    checks++;
    if (ready_cyc - acc_cyc != 67) begin
      failures++; $display("FAIL div0_ready_cycle: got %0d required 67", ready_cyc - acc_cyc);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 6; i++) begin
      int target = rsp_count + 1;
      int d = $urandom_range(0, 3);
      int m = $urandom_range(0, 3);
      logic [DW-1:0] word = $urandom;
      logic [DW-1:0] got, exp;
      exp_q.push_back(word);
      launch(word, d, m[1], m[0]);
      finish_frame(target);
      got = pop_got(); exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin failures++; $display("FAIL random%0d_data: got %h required %h", i, got, exp); end
      checks++;
      if (rv_cyc - acc_cyc != 1 + (2 * DW + 1) * (d + 1) || lead_edges != DW) begin
        failures++;
        $display("FAIL random%0d_timing: rv %0d edges %0d required %0d %0d", i, rv_cyc - acc_cyc,
                 lead_edges, 1 + (2 * DW + 1) * (d + 1), DW);
      end
    end
  endtask

  task automatic test_back_to_back();
    int target = rsp_count + 2;
    int start = acc_count;
    int rif0 = ready_in_frame;
    int spacing;
    logic [DW-1:0] word_a = $urandom;
    logic [DW-1:0] word_b = $urandom;
    logic [DW-1:0] got, exp;
    exp_q.push_back(word_a);
    exp_q.push_back(word_b);
    @(posedge clock); #1;
    request_data = word_a; clock_divider = 16'd2; clock_polarity = 1'b0; clock_phase = 1'b0;
    request_valid = 1'b1;
    wait_accepts(start + 1);
    @(posedge clock); #1;
    request_data = word_b;
    wait_accepts(start + 2);
    @(posedge clock); #1;
    request_valid = 1'b0;
    finish_frame(target);
    for (int k = 0; k < 2; k++) begin
      got = pop_got(); exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin failures++; $display("FAIL b2b_data%0d: got %h required %h", k, got, exp); end
    end
    checks++;
    if (cs_gap < 4) begin failures++; $display("FAIL b2b_cs_gap: got %0d required >= 4", cs_gap); end
    spacing = (acc_hist.size() >= 2) ? acc_hist[acc_hist.size() - 1] - acc_hist[acc_hist.size() - 2] : -1;
    checks++;
    if (spacing != 199) begin failures++; $display("FAIL b2b_accept_spacing: got %0d required 199", spacing); end
    checks++;
    if (ready_in_frame != rif0 || busy_bad != 0) begin
      failures++;
      $display("FAIL b2b_ready_busy: ready_in_frame %0d busy_bad %0d required 0 0", ready_in_frame - rif0, busy_bad);
    end
  endtask

  task automatic test_midframe_change();
    int target = rsp_count + 1;
    logic [DW-1:0] word_x = $urandom;
    logic [DW-1:0] word_y = $urandom;
    logic [DW-1:0] got, exp;
    exp_q.push_back(word_x);
    launch(word_x, 1, 1'b0, 1'b0);
    repeat (20) @(negedge clock);
    #1;
    clock_polarity = 1'b1; clock_phase = 1'b1; clock_divider = 16'd5; request_data = word_y;
    finish_frame(target);
    got = pop_got(); exp = exp_q.pop_front();
    checks++;
    if (got !== exp) begin failures++; $display("FAIL midframe_data: got %h required %h", got, exp); end
    checks++;
    if (rv_cyc - acc_cyc != 131 || lead_edges != DW) begin
      failures++;
      $display("FAIL midframe_timing: rv %0d edges %0d required 131 %0d", rv_cyc - acc_cyc, lead_edges, DW);
    end
    repeat (2) @(negedge clock);
    checks++;
    if (serial_clock !== 1'b1) begin failures++; $display("FAIL midframe_idle_sclk: got %b required 1", serial_clock); end
    target = rsp_count + 1;
    exp_q.push_back(word_y);
    launch(word_y, 5, 1'b1, 1'b1);
    finish_frame(target);
    got = pop_got(); exp = exp_q.pop_front();
    checks++;
    if (got !== exp) begin failures++; $display("FAIL newmode_data: got %h required %h", got, exp); end
    checks++;
    if (rv_cyc - acc_cyc != 391 || lead_edges != DW) begin
      failures++;
      $display("FAIL newmode_timing: rv %0d edges %0d required 391 %0d", rv_cyc - acc_cyc, lead_edges, DW);
    end
  endtask

  task automatic test_reset_midframe();
    int n = 0;
    int rsp0 = rsp_count;
    int target;
    logic [DW-1:0] word = $urandom;
    logic [DW-1:0] got, exp;
    launch($urandom, 1, 1'b0, 1'b0);
    while (toggles < 20 && n < BUDGET) begin @(negedge clock); #1; n++; end
    if (toggles < 20) begin checks++; failures++; $display("FAIL tick20_timeout: toggles %0d required 20", toggles); end
    reset_n = 1'b0;
    #1;
    checks++;
    if ({chip_select, serial_clock, serial_out, busy, request_ready, response_valid} !== 6'b100010) begin
      failures++;
      $display("FAIL midreset_pins: got %b required 100010",
               {chip_select, serial_clock, serial_out, busy, request_ready, response_valid});
    end
    repeat (3) @(negedge clock);
    #1 reset_n = 1'b1;
    repeat (150) @(negedge clock);
    checks++;
    if (rsp_count != rsp0) begin failures++; $display("FAIL midreset_no_response: got %0d required %0d", rsp_count, rsp0); end
    target = rsp_count + 1;
    exp_q.push_back(word);
    launch(word, 2, 1'b1, 1'b1);
    finish_frame(target);
    got = pop_got(); exp = exp_q.pop_front();
    checks++;
    if (got !== exp) begin failures++; $display("FAIL postreset_data: got %h required %h", got, exp); end
    checks++;
    if (rv_cyc - acc_cyc != 196) begin
      failures++; $display("FAIL postreset_rv_cycle: got %0d required 196", rv_cyc - acc_cyc);
    end
  endtask

  initial begin
    test_reset();
    test_slave_mode0();
    test_modes();
    test_divider_zero();
    test_random();
    test_back_to_back();
    test_midframe_change();
    test_reset_midframe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
